fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch controller that sequences the program counter into the instruction memory and delivers fetched words to decode over a valid/ready handshake. Sits between the combinational-read instruction memory (addressed by byte PC, one 32-bit word per 4-byte step) and the decode stage. Buffers up to two fetched entries so decode back-pressure never drops an instruction. Handles control-flow redirects and faults on out-of-range or misaligned PCs.

## Interface
- PC_RESET, 32'h0000_0000, PC loaded on reset; must be word-aligned
- MEM_SIZE, 256, instruction memory depth in words; valid byte PCs are 0 .. 4*MEM_SIZE-4
- clk  in  1  rising-edge clock
- resetN  in  1  reset, synchronous, active-low
- imem_addr  out  32  fetch address to instruction memory; equals current PC
- imem_data  in  32  instruction word returned combinationally for imem_addr
- redirect_valid  in  1  single-cycle request to flush and jump
- redirect_pc  in  32  jump target, sampled when redirect_valid=1
- if_valid  out  1  head entry available to decode
- if_instr  out  32  head entry instruction
- if_pc  out  32  head entry PC
- if_ready  in  1  decode accepts head entry this cycle
- fetch_fault  out  1  controller is in FAULT

## Operation
- States: RUN, FULL, FAULT. Reset -> RUN, pc=PC_RESET, buffer empty, all outputs 0 except imem_addr=PC_RESET.
- pop = if_valid & if_ready. space = (count<2) | pop.
- RUN: if no redirect and space and PC in range, push {pc, imem_data}, pc <= pc+4. If count becomes 2 without pop -> FULL.
- FULL: no push; pc holds. On pop -> RUN (push resumes next cycle, not same cycle).
- Redirect (any state): buffer flushed (count=0), pc <= redirect_pc, no push that cycle. Aligned and in-range target -> RUN; otherwise -> FAULT. A coincident pop completes (handshake honored), entry is discarded by the flush.
- Range check in RUN: pc >= 4*MEM_SIZE -> FAULT, no push. pc+4 wraps mod 2^32; wrap to 0 is not reachable without first faulting.
- FAULT: no pushes; existing buffered entries still drain to decode (redirect flushes them). fetch_fault=1. Exit only via valid redirect or reset.
- Reset mid-operation: buffer cleared, state RUN, pc=PC_RESET, regardless of handshake in progress.
- Buffer order strictly FIFO; if_instr/if_pc stable while if_valid=1 and if_ready=0.

## Timing
- Fetch latency: PC presented cycle N -> if_valid with that entry cycle N+1.
- Throughput: 1 instruction/cycle with if_ready held high.
- Redirect asserted cycle N -> target entry on if_valid cycle N+2; if_valid=0 in cycle N+1.
- Fault: fetch_fault asserts the cycle after the offending PC or redirect.
- FULL -> RUN: one bubble in push after first pop.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32, count of pushes) and perf_stalled (32, cycles with if_valid=1 & if_ready=0); both reset to 0, saturate at 32'hFFFF_FFFF, do not clear on redirect.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package fetch_pkg: fetch_state_e (RUN, FULL, FAULT), fetch_entry_t {pc[31:0], instr[31:0]}, INSTR_W=32, PC_STEP=4.
- Sub-module fetch_buf: 2-entry FIFO of fetch_entry_t with push, pop, flush, count; fetch_ctrl owns PC and state machine.

## Test plan
- Reset, imem words 0x00218020 @0, 0x00014820 @4, if_ready=1 -> if_pc 0 then 4 on consecutive cycles starting cycle 1 after reset.
- if_ready=0 for 5 cycles from reset -> exactly two entries buffered (pc 0, 4), pc holds at 8, if_instr stable; raise if_ready -> pc 0,4,8 delivered in order, no gap except FULL->RUN bubble.
- redirect_valid with redirect_pc=0x40 while buffer full -> if_valid=0 next cycle, if_pc=0x40 two cycles after redirect.
- Run to pc=4*MEM_SIZE (0x400) -> fetch_fault=1, last entry pc 0x3FC delivered, no further pushes; redirect to 0x10 clears fault.
- redirect_pc=0x06 -> FAULT, fetch_fault=1; resetN=0 one cycle -> fault clears, pc=PC_RESET, buffer empty.
- FETCH_PERF_EN: 10 fetches with 3 stall cycles -> perf_fetched counts pushes, perf_stalled=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FULL  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // A jump target is usable only if it is word-aligned and inside the memory.
  function automatic logic pc_target_ok(input logic [31:0] pc, input logic [31:0] limit);
    return (pc[1:0] == 2'b00) && (pc < limit);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, instr} entries between fetch and decode.
// Latency: a pushed entry is visible at head_o the cycle after the push.
// Backpressure: caller must not push when full without a same-cycle pop; flush wins over push/pop.
// Ports: clk, resetN (sync, active-low); push_i/push_entry_i write, pop_i removes head,
//        flush_i empties; head_o is the oldest entry, count_o the occupancy (0..2).
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         resetN,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t e0_q, e0_d;  // head slot
  fetch_entry_t e1_q, e1_d;  // second-oldest slot
  logic [1:0]   count_q, count_d;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) e0_d = push_entry_i;
          else                 e1_d = push_entry_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (count_q == 2'd1) begin
            e0_d = push_entry_i;
          end else begin
            e0_d = e1_q;
            e1_d = push_entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = e0_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: walks the PC through a combinational imem and buffers words for decode.
// Latency: PC presented in cycle N appears on if_valid in N+1; redirect target appears in N+2.
// Backpressure: two-entry buffer absorbs if_ready=0; fetch stalls (FULL) rather than dropping words.
// Ports: clk, resetN (sync, active-low); imem_addr/imem_data to instruction memory;
//        redirect_valid/redirect_pc flush-and-jump; if_valid/if_instr/if_pc/if_ready to decode;
//        fetch_fault high while faulted. With FETCH_PERF_EN defined, perf_fetched and
//        perf_stalled saturating event counters are added.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          MEM_SIZE = 256
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled
`endif
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * MEM_SIZE);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         pop, space, pc_in_range, push;

  assign pop         = if_valid & if_ready;
  assign space       = (count < 2'd2) | pop;
  assign pc_in_range = pc_q < PC_LIMIT;
  // Only RUN fetches; a redirect cycle never pushes because the buffer is being flushed.
  assign push        = !redirect_valid && (state_q == RUN) && space && pc_in_range;

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_data;

  fetch_buf u_buf (
    .clk          (clk),
    .resetN       (resetN),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .head_o       (head),
    .count_o      (count)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= RUN;
      pc_q    <= PC_RESET;
    end else if (redirect_valid) begin
      pc_q    <= redirect_pc;
      state_q <= pc_target_ok(redirect_pc, PC_LIMIT) ? RUN : FAULT;
    end else begin
      case (state_q)
        RUN: begin
          if (!pc_in_range) begin
            state_q <= FAULT;
          end else if (space) begin
            pc_q <= pc_q + PC_STEP;
            // Second entry going in with nothing leaving fills the buffer.
            if ((count == 2'd1) && !pop) state_q <= FULL;
          end
        end
        // Return to RUN on the pop; the push itself waits a cycle.
        FULL:    if (pop) state_q <= RUN;
        FAULT:   ;
        default: state_q <= RUN;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = (count != 2'd0);
  assign if_instr    = head.instr;
  assign if_pc       = head.pc;
  assign fetch_fault = (state_q == FAULT);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stalled_q;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      perf_fetched_q <= '0;
      perf_stalled_q <= '0;
    end else begin
      if (push && (perf_fetched_q != 32'hFFFF_FFFF))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (if_valid && !if_ready && (perf_stalled_q != 32'hFFFF_FFFF))
        perf_stalled_q <= perf_stalled_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalled = perf_stalled_q;
`endif

endmodule
